// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants, arbiter state encoding and helpers
package rf_pkg;

    localparam int RF_ADDR_W = 4;
    localparam int RF_DATA_W = 16;

    localparam logic RF_READ  = 1'b0;
    localparam logic RF_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Burst counter stops at the limit so a long uncontended burst never wraps.
    function automatic logic [7:0] burst_inc(input logic [7:0] cnt, input logic [7:0] limit);
        return (cnt >= limit) ? limit : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker, one-hot grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the port that did not win last time goes next.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-port round-robin arbiter with locked bursts for the shared register file
module regfile_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int DATA_W    = RF_DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] da0,
    input  logic [ADDR_W-1:0] da1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] aa0,
    input  logic [ADDR_W-1:0] aa1,
    input  logic [ADDR_W-1:0] ba0,
    input  logic [ADDR_W-1:0] ba1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_d,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_da,
    output logic [ADDR_W-1:0] rf_aa,
    output logic [ADDR_W-1:0] rf_ba,
    output logic [DATA_W-1:0] rf_d,
    input  logic [DATA_W-1:0] rf_aout,
    input  logic [DATA_W-1:0] rf_bout,
    input  logic [DATA_W-1:0] rf_dout
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    arb_state_t  state;
    logic        last;
    logic [7:0]  burst_cnt;
    logic [1:0]  rr_gnt;
    logic [1:0]  gnt;

    rr_arb2 u_rr (
        .req  ({req1, req0}),
        .last (last),
        .gnt  (rr_gnt)
    );

    // An owner keeps the port until it lets go, or until it has used its
    // burst allowance while the other port is waiting.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (state)
                OWN0: begin
                    if (req0)
                        gnt = (burst_cnt == BURST_LIMIT && req1) ? 2'b10 : 2'b01;
                    else
                        gnt = rr_gnt;
                end
                OWN1: begin
                    if (req1)
                        gnt = (burst_cnt == BURST_LIMIT && req0) ? 2'b01 : 2'b10;
                    else
                        gnt = rr_gnt;
                end
                default: gnt = rr_gnt;
            endcase
        end
    end

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    always_comb begin
        rf_rw = RF_READ;
        rf_da = '0;
        rf_aa = '0;
        rf_ba = '0;
        rf_d  = '0;
        if (gnt[0]) begin
            rf_rw = we0 ? RF_WRITE : RF_READ;
            rf_da = da0;
            rf_aa = aa0;
            rf_ba = ba0;
            rf_d  = wd0;
        end else if (gnt[1]) begin
            rf_rw = we1 ? RF_WRITE : RF_READ;
            rf_da = da1;
            rf_aa = aa1;
            rf_ba = ba1;
            rf_d  = wd1;
        end
    end

    assign rdata_a = rf_aout;
    assign rdata_b = rf_bout;
    assign rdata_d = rf_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 8'd0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            rvalid0 <= gnt[0] & ~we0;
            rvalid1 <= gnt[1] & ~we1;
            if (gnt[0]) begin
                last      <= 1'b0;
                state     <= lock0 ? OWN0 : IDLE;
                burst_cnt <= (state == OWN0 && lock0) ? burst_inc(burst_cnt, BURST_LIMIT) : 8'd1;
            end else if (gnt[1]) begin
                last      <= 1'b1;
                state     <= lock1 ? OWN1 : IDLE;
                burst_cnt <= (state == OWN1 && lock1) ? burst_inc(burst_cnt, BURST_LIMIT) : 8'd1;
            end else begin
                state     <= IDLE;
                burst_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - self-checking bench for regfile_arbiter with a register-file model
module tb_regfile_arbiter;

    localparam int MAX_BURST = 8;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [3:0]  da0, da1, aa0, aa1, ba0, ba1;
    logic [15:0] wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata_a, rdata_b, rdata_d;
    logic        rf_rw;
    logic [3:0]  rf_da, rf_aa, rf_ba;
    logic [15:0] rf_d;
    logic [15:0] rf_aout, rf_bout, rf_dout;

    int checks = 0;
    int failures = 0;

    regfile_arbiter #(.ADDR_W(4), .DATA_W(16), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .da0(da0), .da1(da1), .wd0(wd0), .wd1(wd1),
        .aa0(aa0), .aa1(aa1), .ba0(ba0), .ba1(ba1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .rdata_d(rdata_d),
        .rf_rw(rf_rw), .rf_da(rf_da), .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_d(rf_d),
        .rf_aout(rf_aout), .rf_bout(rf_bout), .rf_dout(rf_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: each register starts at its own index, registered read ports.
    logic [15:0] rf_mem [16] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7,
                                 16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15};
    always @(posedge clk) begin
        if (rf_rw) rf_mem[rf_da] <= rf_d;
        rf_aout <= rf_mem[rf_aa];
        rf_bout <= rf_mem[rf_ba];
        rf_dout <= rf_mem[rf_da];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        da0 = 0; da1 = 0; aa0 = 0; aa1 = 0; ba0 = 0; ba1 = 0; wd0 = 0; wd1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    typedef struct {
        bit r0, r1, l0, l1;
        bit g0, g1;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(bit r0, bit r1, bit l0, bit l1, bit g0, bit g1, int n);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.g0 = g0; v.g1 = g1;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    // Reference model state for the random phase.
    logic [15:0] exp_mem [16];
    int          own, lst, cnt, g, prev_g;
    bit          r[2], w[2], l[2];
    logic [3:0]  rda[2], raa[2], rba[2];
    logic [15:0] rwd[2];
    bit          pv0, pv1, rst_now;
    logic [15:0] pa, pb, pd;

    function automatic int model_pick();
        if (own >= 0 && r[own]) begin
            if (cnt >= MAX_BURST && r[1-own]) return 1 - own;
            return own;
        end
        if (r[0] && r[1]) return 1 - lst;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    initial begin
        bit pg0, pg1;
        for (int i = 0; i < 16; i++) exp_mem[i] = 16'(i);
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        @(negedge clk);
        chk("reset_gnt0", gnt0, 0);
        chk("reset_gnt1", gnt1, 0);
        chk("reset_rvalid0", rvalid0, 0);
        chk("reset_rvalid1", rvalid1, 0);
        chk("reset_rf_rw", rf_rw, 0);
        tick();

        // Read of initial contents, then write followed by read of the same register.
        req0 = 1; we0 = 0; aa0 = 3; ba0 = 5; da0 = 7;
        @(negedge clk);
        chk("rd_gnt0", gnt0, 1);
        chk("rd_gnt1", gnt1, 0);
        chk("rd_rf_aa", rf_aa, 3);
        chk("rd_rf_ba", rf_ba, 5);
        chk("rd_rf_da", rf_da, 7);
        chk("rd_rf_rw", rf_rw, 0);
        tick();
        req0 = 0; req1 = 1; we1 = 1; da1 = 4; wd1 = 16'hBEEF;
        @(negedge clk);
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata_a", rdata_a, 3);
        chk("rd_rdata_b", rdata_b, 5);
        chk("rd_rdata_d", rdata_d, 7);
        chk("wr_gnt1", gnt1, 1);
        chk("wr_rf_rw", rf_rw, 1);
        chk("wr_rf_da", rf_da, 4);
        chk("wr_rf_d", rf_d, 16'hBEEF);
        tick();
        req1 = 0; we1 = 0; req0 = 1; aa0 = 4; ba0 = 0; da0 = 0;
        @(negedge clk);
        chk("raw_gnt0", gnt0, 1);
        chk("wr_rvalid1", rvalid1, 0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("raw_rvalid0", rvalid0, 1);
        chk("raw_rvalid1", rvalid1, 0);
        chk("raw_rdata_a", rdata_a, 16'hBEEF);
        chk("idle_rf_rw", rf_rw, 0);
        chk("idle_rf_da", rf_da, 0);
        chk("idle_gnt", {gnt1, gnt0}, 0);
        exp_mem[4] = 16'hBEEF;
        tick();

        // Table: alternation, forced handoff at the burst limit, uncontended long burst.
        do_reset();
        add(1, 1, 0, 0, 1, 0, 1); add(1, 1, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 1, 0, 1); add(1, 1, 0, 0, 0, 1, 1);
        add(1, 1, 1, 0, 1, 0, MAX_BURST);
        add(1, 1, 1, 0, 0, 1, 1);
        add(1, 1, 1, 0, 1, 0, 1);
        add(1, 0, 1, 0, 1, 0, 25);
        add(1, 1, 1, 0, 0, 1, 1);
        add(1, 1, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        pg0 = 0; pg1 = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; lock0 = vecs[i].l0; lock1 = vecs[i].l1;
            we0 = 0; we1 = 0; aa0 = 1; aa1 = 2;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt0", i), gnt0, vecs[i].g0);
            chk($sformatf("tbl%0d_gnt1", i), gnt1, vecs[i].g1);
            chk($sformatf("tbl%0d_rvalid", i), {rvalid1, rvalid0}, {pg1, pg0});
            pg0 = vecs[i].g0; pg1 = vecs[i].g1;
            tick();
        end

        // Reset on the third cycle of a locked write burst.
        do_reset();
        req1 = 1; we1 = 1; lock1 = 1; da1 = 9; wd1 = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("burst_gnt1", gnt1, 1);
            tick();
        end
        exp_mem[9] = 16'h1234;
        reset = 1; req0 = 1; we0 = 0; aa0 = 9; ba0 = 4; da0 = 3;
        @(negedge clk);
        chk("inrst_gnt0", gnt0, 0);
        chk("inrst_gnt1", gnt1, 0);
        chk("inrst_rf_rw", rf_rw, 0);
        chk("inrst_rf_da", rf_da, 0);
        chk("inrst_rf_aa", rf_aa, 0);
        chk("inrst_rf_d", rf_d, 0);
        tick();
        reset = 0;
        @(negedge clk);
        chk("postrst_gnt0", gnt0, 1);
        chk("postrst_gnt1", gnt1, 0);
        tick();
        req0 = 0;
        @(negedge clk);
        chk("postrst_rvalid0", rvalid0, 1);
        chk("postrst_rdata_a", rdata_a, 16'h1234);
        chk("postrst_rdata_b", rdata_b, 16'hBEEF);
        chk("postrst_next_gnt1", gnt1, 1);
        tick();

        // Random traffic against the reference model.
        do_reset();
        own = -1; lst = 1; cnt = 0; prev_g = -1; pv0 = 0; pv1 = 0;
        pa = 0; pb = 0; pd = 0;
        for (int p = 0; p < 2; p++) begin
            r[p] = 0; w[p] = 0; l[p] = 0; rda[p] = 0; raa[p] = 0; rba[p] = 0; rwd[p] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            rst_now = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!r[p] || prev_g == p) begin
                    r[p]   = ($urandom_range(0, 3) != 0);
                    w[p]   = 1'($urandom_range(0, 1));
                    l[p]   = ($urandom_range(0, 2) != 0);
                    rda[p] = 4'($urandom_range(0, 15));
                    raa[p] = 4'($urandom_range(0, 15));
                    rba[p] = 4'($urandom_range(0, 15));
                    rwd[p] = 16'($urandom);
                end
            end
            reset = rst_now;
            req0 = r[0]; we0 = w[0]; lock0 = l[0]; da0 = rda[0]; aa0 = raa[0]; ba0 = rba[0]; wd0 = rwd[0];
            req1 = r[1]; we1 = w[1]; lock1 = l[1]; da1 = rda[1]; aa1 = raa[1]; ba1 = rba[1]; wd1 = rwd[1];
            @(negedge clk);
            g = rst_now ? -1 : model_pick();
            chk("rnd_gnt0", gnt0, g == 0);
            chk("rnd_gnt1", gnt1, g == 1);
            chk("rnd_onehot", gnt0 & gnt1, 0);
            chk("rnd_rf_rw", rf_rw, (g >= 0) ? w[g] : 1'b0);
            chk("rnd_rf_da", rf_da, (g >= 0) ? rda[g] : 4'd0);
            chk("rnd_rf_aa", rf_aa, (g >= 0) ? raa[g] : 4'd0);
            chk("rnd_rf_ba", rf_ba, (g >= 0) ? rba[g] : 4'd0);
            chk("rnd_rf_d", rf_d, (g >= 0) ? rwd[g] : 16'd0);
            chk("rnd_rvalid", {rvalid1, rvalid0}, {pv1, pv0});
            if (pv0 || pv1) begin
                chk("rnd_rdata_a", rdata_a, pa);
                chk("rnd_rdata_b", rdata_b, pb);
                chk("rnd_rdata_d", rdata_d, pd);
            end
            pv0 = (g == 0) && !w[0];
            pv1 = (g == 1) && !w[1];
            if (g >= 0) begin
                if (w[g]) begin
                    exp_mem[rda[g]] = rwd[g];
                end else begin
                    pa = exp_mem[raa[g]];
                    pb = exp_mem[rba[g]];
                    pd = exp_mem[rda[g]];
                end
            end
            if (rst_now) begin
                own = -1; lst = 1; cnt = 0;
            end else if (g >= 0) begin
                cnt = (own == g && l[g]) ? ((cnt >= MAX_BURST) ? MAX_BURST : cnt + 1) : 1;
                own = l[g] ? g : -1;
                lst = g;
            end else begin
                own = -1;
            end
            prev_g = g;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
